// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  localparam int RD_MAX_W = 8;
  localparam int IF_STG   = 0;
  localparam int ID_STG   = 1;
  localparam int EX_STG   = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  // x0 is hardwired, so a writer of x0 never creates a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic used,
                                    input logic [RD_MAX_W-1:0] addr);
    return used && e.valid && (e.rd != {RD_MAX_W{1'b0}}) && (e.rd == addr);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight register writers with youngest-match search.
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int NUM_STAGES = 5,
  parameter int SEL_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  sb_entry_t           entry_in,
  input  logic                rs1_used,
  input  logic [RD_MAX_W-1:0] rs1_addr,
  input  logic                rs2_used,
  input  logic [RD_MAX_W-1:0] rs2_addr,
  output logic [SEL_W-1:0]    rs1_stg,
  output logic                rs1_load,
  output logic [SEL_W-1:0]    rs2_stg,
  output logic                rs2_load
);

  sb_entry_t sb_r [EX_STG:NUM_STAGES-1];

  // Entries advance one stage per cycle; the WB entry falls off the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = EX_STG; k < NUM_STAGES; k++) sb_r[k] <= '0;
    end else begin
      sb_r[EX_STG] <= entry_in;
      for (int k = EX_STG + 1; k < NUM_STAGES; k++) sb_r[k] <= sb_r[k-1];
    end
  end

  // Scan oldest to youngest so the youngest match (smallest k) is left last.
  // WB is excluded: the write-first register file already covers it.
  always_comb begin
    rs1_stg  = {SEL_W{1'b0}};
    rs1_load = 1'b0;
    rs2_stg  = {SEL_W{1'b0}};
    rs2_load = 1'b0;
    for (int k = NUM_STAGES - 2; k >= EX_STG; k--) begin
      rs1_stg  = sb_match(sb_r[k], rs1_used, rs1_addr) ? SEL_W'(k) : rs1_stg;
      rs1_load = sb_match(sb_r[k], rs1_used, rs1_addr) ? sb_r[k].is_load : rs1_load;
      rs2_stg  = sb_match(sb_r[k], rs2_used, rs2_addr) ? SEL_W'(k) : rs2_stg;
      rs2_load = sb_match(sb_r[k], rs2_used, rs2_addr) ? sb_r[k].is_load : rs2_load;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall/flush vectors, EX forwarding, halt drain.
// Optional feature macro: HAZARD_FWD_EN (operand forwarding; without it, RAW hazards stall).
import hazard_pkg::*;

module hazard_ctrl_unit #(
  parameter  int NUM_STAGES = 5,
  parameter  int REG_AW     = 5,
  parameter  int LOAD_STAGE = 3,
  localparam int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs1_addr,
  input  logic [REG_AW-1:0]     id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     id_rd_addr,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  id_is_halt,
  input  logic                  ex_branch_taken,
  input  logic                  resume,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [SEL_W-1:0]      fwd_rs1_sel,
  output logic [SEL_W-1:0]      fwd_rs2_sel,
  output logic                  halted
);

  hz_state_e             state_r, state_next_s;
  logic [SEL_W-1:0]      cnt_r, cnt_next_s;
  logic                  halted_r;
  logic [NUM_STAGES-1:0] stall_s, flush_s;
  logic                  accept_s;
  sb_entry_t             entry_s;
  logic [SEL_W-1:0]      rs1_stg_s, rs2_stg_s;
  logic                  rs1_load_s, rs2_load_s;
  logic [SEL_W:0]        rs1_pos_s, rs2_pos_s;
  logic                  load_use_s, hazard_s;

  hazard_scoreboard #(
    .NUM_STAGES (NUM_STAGES),
    .SEL_W      (SEL_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .entry_in (entry_s),
    .rs1_used (id_valid && id_rs1_used),
    .rs1_addr (RD_MAX_W'(id_rs1_addr)),
    .rs2_used (id_valid && id_rs2_used),
    .rs2_addr (RD_MAX_W'(id_rs2_addr)),
    .rs1_stg  (rs1_stg_s),
    .rs1_load (rs1_load_s),
    .rs2_stg  (rs2_stg_s),
    .rs2_load (rs2_load_s)
  );

  // Halts and non-writers occupy a slot but never match.
  always_comb begin
    entry_s.valid   = accept_s && id_rd_we && !id_is_halt;
    entry_s.rd      = RD_MAX_W'(id_rd_addr);
    entry_s.is_load = id_is_load;
  end

  // Match positions are judged where the producer will sit next cycle.
  assign rs1_pos_s = {1'b0, rs1_stg_s} + {{SEL_W{1'b0}}, 1'b1};
  assign rs2_pos_s = {1'b0, rs2_stg_s} + {{SEL_W{1'b0}}, 1'b1};

  assign load_use_s =
      ((rs1_stg_s != {SEL_W{1'b0}}) && rs1_load_s && (rs1_pos_s <= (SEL_W+1)'(LOAD_STAGE))) ||
      ((rs2_stg_s != {SEL_W{1'b0}}) && rs2_load_s && (rs2_pos_s <= (SEL_W+1)'(LOAD_STAGE)));

`ifdef HAZARD_FWD_EN
  assign hazard_s = load_use_s;
`else
  assign hazard_s = load_use_s || (rs1_stg_s != {SEL_W{1'b0}}) || (rs2_stg_s != {SEL_W{1'b0}});
`endif

  // Next state, drain counter and per-stage stall/flush, in priority order.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    stall_s      = {NUM_STAGES{1'b0}};
    flush_s      = {NUM_STAGES{1'b0}};
    accept_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (ex_branch_taken) begin
          flush_s[ID_STG:IF_STG] = 2'b11;
        end else if (hazard_s) begin
          stall_s[ID_STG:IF_STG] = 2'b11;
          flush_s[EX_STG]        = 1'b1;
        end else begin
          accept_s = id_valid;
          if (id_valid && id_is_halt) begin
            state_next_s = DRAIN;
            cnt_next_s   = SEL_W'(NUM_STAGES - 2);
          end else begin
            state_next_s = RUN;
          end
        end
      end
      DRAIN: begin
        stall_s[ID_STG:IF_STG] = 2'b11;
        flush_s[EX_STG]        = 1'b1;
        if (cnt_r <= {{(SEL_W-1){1'b0}}, 1'b1}) begin
          cnt_next_s   = {SEL_W{1'b0}};
          state_next_s = HALTED;
        end else begin
          cnt_next_s = cnt_r - {{(SEL_W-1){1'b0}}, 1'b1};
        end
      end
      HALTED: begin
        stall_s = {NUM_STAGES{1'b1}};
        if (resume) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALTED;
        end
      end
      default: begin
        state_next_s = RUN;
        cnt_next_s   = {SEL_W{1'b0}};
      end
    endcase
  end

  // FSM state, drain counter and halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= RUN;
      cnt_r    <= {SEL_W{1'b0}};
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      halted_r <= (state_next_s == HALTED);
    end
  end

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign halted = halted_r;

`ifdef HAZARD_FWD_EN
  logic [SEL_W-1:0] fwd_rs1_r, fwd_rs2_r;

  // Selects follow the instruction into EX and hold while ID is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_rs1_r <= {SEL_W{1'b0}};
      fwd_rs2_r <= {SEL_W{1'b0}};
    end else if (stall_s[ID_STG]) begin
      fwd_rs1_r <= fwd_rs1_r;
      fwd_rs2_r <= fwd_rs2_r;
    end else if (accept_s) begin
      fwd_rs1_r <= (rs1_stg_s != {SEL_W{1'b0}}) ? rs1_pos_s[SEL_W-1:0] : {SEL_W{1'b0}};
      fwd_rs2_r <= (rs2_stg_s != {SEL_W{1'b0}}) ? rs2_pos_s[SEL_W-1:0] : {SEL_W{1'b0}};
    end else begin
      fwd_rs1_r <= {SEL_W{1'b0}};
      fwd_rs2_r <= {SEL_W{1'b0}};
    end
  end

  assign fwd_rs1_sel = fwd_rs1_r;
  assign fwd_rs2_sel = fwd_rs2_r;
`else
  assign fwd_rs1_sel = {SEL_W{1'b0}};
  assign fwd_rs2_sel = {SEL_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit (default parameters).
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_halt;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       ex_branch_taken, resume;
  logic [4:0] stall, flush;
  logic [2:0] fwd_rs1_sel, fwd_rs2_sel;
  logic       halted;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd_addr      (id_rd_addr),
    .id_rd_we        (id_rd_we),
    .id_is_load      (id_is_load),
    .id_is_halt      (id_is_halt),
    .ex_branch_taken (ex_branch_taken),
    .resume          (resume),
    .stall           (stall),
    .flush           (flush),
    .fwd_rs1_sel     (fwd_rs1_sel),
    .fwd_rs2_sel     (fwd_rs2_sel),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic hlt);
    id_valid    = v;
    id_rs1_addr = r1;
    id_rs1_used = u1;
    id_rs2_addr = r2;
    id_rs2_used = u2;
    id_rd_addr  = rd;
    id_rd_we    = we;
    id_is_load  = ld;
    id_is_halt  = hlt;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst             = 1'b0;
    resume          = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
    #12;
    chk("rst_stall",  32'(stall),       32'h0);
    chk("rst_flush",  32'(flush),       32'h0);
    chk("rst_fwd1",   32'(fwd_rs1_sel), 32'h0);
    chk("rst_fwd2",   32'(fwd_rs2_sel), 32'h0);
    chk("rst_halted", 32'(halted),      32'h0);
    rst = 1'b1;
    tick();

    // add x5,x1,x2 ; sub x6,x5,x3
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1 chk("add_stall", 32'(stall), 32'h0);
    tick();
    chk("add_fwd1", 32'(fwd_rs1_sel), 32'h0);
    drive(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_FWD_EN
    #1 chk("sub_stall", 32'(stall), 32'h0);
    tick();
    chk("sub_fwd1", 32'(fwd_rs1_sel), 32'h3);
    chk("sub_fwd2", 32'(fwd_rs2_sel), 32'h0);
`else
    #1 chk("sub_stall_a", 32'(stall), 32'h03);
    chk("sub_flush_a", 32'(flush), 32'h04);
    tick();
    chk("sub_stall_b", 32'(stall), 32'h03);
    tick();
    chk("sub_stall_c", 32'(stall), 32'h00);
    tick();
    chk("sub_fwd1", 32'(fwd_rs1_sel), 32'h0);
`endif
    idle();
    repeat (3) tick();

    // lw x7,0(x1) ; add x8,x7,x1
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", 32'(stall), 32'h03);
    chk("lu_flush", 32'(flush), 32'h04);
    tick();
`ifdef HAZARD_FWD_EN
    chk("lu_fwd_hold", 32'(fwd_rs1_sel), 32'h0);
    chk("lu_stall_after", 32'(stall), 32'h00);
    tick();
    chk("lu_fwd1", 32'(fwd_rs1_sel), 32'h4);
    chk("lu_fwd2", 32'(fwd_rs2_sel), 32'h0);
`else
    chk("lu_stall_b", 32'(stall), 32'h03);
    tick();
    chk("lu_stall_c", 32'(stall), 32'h00);
    tick();
    chk("lu_fwd1", 32'(fwd_rs1_sel), 32'h0);
`endif
    idle();
    repeat (3) tick();

    // writer of x0, then reader of x0 on both sources
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 chk("x0_stall", 32'(stall), 32'h0);
    tick();
    chk("x0_fwd1", 32'(fwd_rs1_sel), 32'h0);
    chk("x0_fwd2", 32'(fwd_rs2_sel), 32'h0);
    idle();
    repeat (3) tick();

    // load-use pair in ID together with a taken branch
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1 chk("br_lu_flush", 32'(flush), 32'h03);
    chk("br_lu_stall", 32'(stall), 32'h00);
    tick();
    ex_branch_taken = 1'b0;
    idle();
    repeat (3) tick();

    // halt in ID together with a taken branch: branch wins
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    ex_branch_taken = 1'b1;
    #1 chk("br_halt_flush", 32'(flush), 32'h03);
    chk("br_halt_stall", 32'(stall), 32'h00);
    tick();
    ex_branch_taken = 1'b0;
    idle();
    #1 chk("br_halt_run", 32'(stall), 32'h00);
    tick();
    chk("br_halt_halted", 32'(halted), 32'h0);

    // halt accepted: drain, park, resume
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("halt_acc_stall", 32'(stall), 32'h00);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain%0d_stall", i), 32'(stall), 32'h03);
      chk($sformatf("drain%0d_flush", i), 32'(flush), 32'h04);
      chk($sformatf("drain%0d_halted", i), 32'(halted), 32'h0);
      tick();
    end
    chk("halted_flag", 32'(halted), 32'h1);
    chk("halted_stall", 32'(stall), 32'h1f);
    chk("halted_flush", 32'(flush), 32'h00);
    tick();
    chk("halted_stay", 32'(halted), 32'h1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_stall", 32'(stall), 32'h00);
    tick();

    // asynchronous reset mid-DRAIN
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("pre_rst_stall", 32'(stall), 32'h03);
    rst = 1'b0;
    #1 chk("rst_drain_stall", 32'(stall), 32'h00);
    chk("rst_drain_flush", 32'(flush), 32'h00);
    #2 rst = 1'b1;
    tick();
    chk("rst_drain_run", 32'(stall), 32'h00);
    chk("rst_drain_halted", 32'(halted), 32'h0);

    // asynchronous reset while HALTED
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    chk("pre_rst_halted", 32'(halted), 32'h1);
    rst = 1'b0;
    #1 chk("rst_halt_halted", 32'(halted), 32'h0);
    chk("rst_halt_stall", 32'(stall), 32'h00);
    #2 rst = 1'b1;
    tick();
    chk("rst_halt_run", 32'(stall), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
